unreg_seq: RTL and testbench



---
 rtl/unreg_seq_if.sv | 25 ++
 rtl/unreg_seq.sv | 111 +++++++++++
 tb/tb_unreg_seq.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/unreg_seq_if.sv
// Command/response handshake bundle for the unreg_seq sequencer.
// The master issues commands and takes responses; the slave is the sequencer.
interface unreg_seq_if #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNTW-1:0]  cmd_amt;
  logic [WIDTH-1:0] cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_amt, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_amt, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/unreg_seq.sv
// Command-driven sequencer around a universal load/shift/rotate register:
// accepts one command, steps the register one bit per cycle, returns the result.
module unreg_seq #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       ser_in,
  unreg_seq_if.slave bus,
  output logic [1:0] mode,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHL  = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_ROL  = 2'b11;

  state_t           state, state_nx;
  logic [WIDTH-1:0] q;
  logic [CNTW-1:0]  cnt;
  logic [1:0]       op_r;
  logic             accept;
  logic             last_step;

  // clear suppresses acceptance in the same cycle, so it also masks cmd_ready
  assign bus.cmd_ready = (state == IDLE) && !clear;
  assign bus.rsp_valid = (state == DONE);
  assign bus.rsp_data  = q;
  assign busy          = (state != IDLE);
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign last_step     = (cnt == CNTW'(1));

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    state_nx = state;
    mode     = 2'b00;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.cmd_op == OP_LOAD) begin
            state_nx = DONE;
            mode     = 2'b11;
          end else if (bus.cmd_amt == '0) begin
            state_nx = DONE;
          end else begin
            state_nx = RUN;
          end
        end
      end
      RUN: begin
        mode = op_r;
        if (last_step) state_nx = DONE;
      end
      DONE: begin
        if (bus.rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (clear) state_nx = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      cnt  <= '0;
      op_r <= OP_LOAD;
    end else if (clear) begin
      q   <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (bus.cmd_op == OP_LOAD) begin
              q <= bus.cmd_data;
            end else if (bus.cmd_amt != '0) begin
              cnt  <= bus.cmd_amt;
              op_r <= bus.cmd_op;
            end
          end
        end
        RUN: begin
          cnt <= cnt - CNTW'(1);
          case (op_r)
            OP_SHL:  q <= {q[WIDTH-2:0], ser_in};
            OP_SHR:  q <= {ser_in, q[WIDTH-1:1]};
            OP_ROL:  q <= {q[WIDTH-2:0], q[WIDTH-1]};
            default: q <= q;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unreg_seq.sv
// Randomized and directed bench for unreg_seq, checked against an arithmetic
// model of load/shift/rotate with per-step fill bits.
module tb_unreg_seq;

  localparam int WIDTH = 16;
  localparam int CNTW  = 4;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       ser_in;
  logic [1:0] mode;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] model_q;

  unreg_seq_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();

  unreg_seq #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .ser_in (ser_in),
    .bus    (bus),
    .mode   (mode),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Result of a command on value v: fill bit for step k is bits[k-1].
  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] v, input logic [1:0] op,
                                             input int amt, input logic [WIDTH-1:0] data,
                                             input logic [15:0] bits);
    logic [WIDTH-1:0] r;
    r = v;
    if (op == 2'b00) return data;
    for (int k = 0; k < amt; k++) begin
      case (op)
        2'b01:   r = (r * 2) | WIDTH'(bits[k]);
        2'b10:   r = (r / 2) | (WIDTH'(bits[k]) << (WIDTH - 1));
        default: r = (r * 2) | WIDTH'(r[WIDTH-1] ? 1 : 0);
      endcase
    end
    return r;
  endfunction

  task automatic consume();
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    check("rsp_valid_after_take", 32'(bus.rsp_valid), 32'd0);
    check("cmd_ready_after_take", 32'(bus.cmd_ready), 32'd1);
  endtask

  task automatic run_cmd(input logic [1:0] op, input int amt, input logic [WIDTH-1:0] data,
                         input logic [15:0] bits, input bit take);
    int edges;
    int runm;
    int exp_lat;
    logic [WIDTH-1:0] exp_q;
    exp_q   = model(model_q, op, amt, data, bits);
    exp_lat = (op == 2'b00) ? 1 : amt + 1;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_amt   = CNTW'(amt);
    bus.cmd_data  = data;
    #1;
    check("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    if (op == 2'b00) check("mode_load_accept", 32'(mode), 32'd3);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    edges  = 0;
    runm   = 0;
    ser_in = bits[0];
    while (!bus.rsp_valid && edges < 40) begin
      if (mode == op) runm++;
      @(posedge clk);
      #1;
      edges++;
      if (edges < 16) ser_in = bits[edges];
    end
    check("latency", 32'(edges + 1), 32'(exp_lat));
    if (op != 2'b00) check("run_mode_cycles", 32'(runm), 32'(amt));
    check("rsp_data", 32'(bus.rsp_data), 32'(exp_q));
    check("busy_done", 32'(busy), 32'd1);
    check("mode_done", 32'(mode), 32'd0);
    model_q = exp_q;
    if (take) consume();
  endtask

  initial begin
    logic [WIDTH-1:0] hold;
    rst_n         = 1'b0;
    clear         = 1'b0;
    ser_in        = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_amt   = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;
    model_q       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'h0000);
    check("rst_mode", 32'(mode), 32'd0);

    // Directed: load, shift sequences, zero and max counts
    run_cmd(2'b00, 0, 16'hA5C3, 16'h0000, 1'b1);
    run_cmd(2'b00, 0, 16'h8001, 16'h0000, 1'b1);
    run_cmd(2'b01, 3, 16'h0000, 16'hFFFF, 1'b1);
    check("shl3_value", 32'(model_q), 32'h000F);
    run_cmd(2'b00, 0, 16'h8001, 16'h0000, 1'b1);
    run_cmd(2'b10, 3, 16'h0000, 16'h0000, 1'b1);
    check("shr3_value", 32'(model_q), 32'h1000);
    run_cmd(2'b00, 0, 16'h8001, 16'h0000, 1'b1);
    run_cmd(2'b11, 3, 16'h0000, 16'h0000, 1'b1);
    check("rol3_value", 32'(model_q), 32'h000C);
    run_cmd(2'b01, 0, 16'h0000, 16'hFFFF, 1'b1);
    run_cmd(2'b00, 0, 16'h0001, 16'h0000, 1'b1);
    run_cmd(2'b11, 15, 16'h0000, 16'h0000, 1'b1);
    check("rol15_value", 32'(model_q), 32'h8000);

    // Backpressure with a second command waiting
    run_cmd(2'b00, 0, 16'h2468, 16'h0000, 1'b0);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b00;
    bus.cmd_amt   = '0;
    bus.cmd_data  = 16'h1357;
    hold          = 16'h2468;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_rsp_data", 32'(bus.rsp_data), 32'(hold));
      check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    end
    consume();
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    check("bp_second_valid", 32'(bus.rsp_valid), 32'd1);
    check("bp_second_data", 32'(bus.rsp_data), 32'h1357);
    model_q = 16'h1357;
    consume();

    // Synchronous clear on step 2 of SHL amt=8
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b01;
    bus.cmd_amt   = CNTW'(8);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    ser_in        = 1'b1;
    @(posedge clk);
    #1;
    check("clr_busy_before", 32'(busy), 32'd1);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_q", 32'(bus.rsp_data), 32'h0000);
    check("clr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("clr_stays_idle", 32'(bus.rsp_valid), 32'd0);
    model_q = '0;

    // Asynchronous reset mid-RUN
    run_cmd(2'b00, 0, 16'hBEEF, 16'h0000, 1'b1);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b01;
    bus.cmd_amt   = CNTW'(8);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_busy_before", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_q", 32'(bus.rsp_data), 32'h0000);
    check("rst_mid_mode", 32'(mode), 32'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_no_rsp", 32'(bus.rsp_valid), 32'd0);
    check("rst_mid_ready", 32'(bus.cmd_ready), 32'd1);
    model_q = '0;

    // Randomized command stream
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  rop;
      int          ramt;
      logic [15:0] rdata;
      logic [15:0] rbits;
      rop   = 2'($urandom_range(0, 3));
      ramt  = $urandom_range(0, 15);
      rdata = 16'($urandom);
      rbits = 16'($urandom);
      run_cmd(rop, ramt, rdata, rbits, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
